// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle control unit and the RV32I datapath.
// The datapath side is the master; the control unit is the slave.
interface multicycle_control_unit_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
        input  ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite,
        input  illegal_op, state
    );

    modport slave (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
        output ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite,
        output illegal_op, state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control: Moore main FSM, ALU decoder and immediate decoder.
// Write enables are gated by rst_n so nothing commits while reset is held.
module multicycle_control_unit (
    input  logic                             clk,
    input  logic                             rst_n,
    multicycle_control_unit_if.slave         bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t     r_state;
    state_t     w_next;
    logic       w_legal;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_adr_src;
    logic [1:0] w_alu_op;
    logic [1:0] w_result_src;
    logic [1:0] w_src_a;
    logic [1:0] w_src_b;
    logic [2:0] w_alu_ctrl;
    logic [1:0] w_imm_src;

    always_comb begin
        unique case (bus.op)
            OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: w_legal = 1'b1;
            default:                                 w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = S_DECODE;
            S_DECODE: begin
                unique case (bus.op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_JAL:       w_next = S_JAL;
                    OP_BEQ:       w_next = S_BEQ;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: w_next = S_MEMWB;
            S_EXECR,
            S_EXECI,
            S_JAL:     w_next = S_ALUWB;
            default:   w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_alu_op     = 2'b00;
        w_result_src = 2'b00;
        w_src_a      = 2'b00;
        w_src_b      = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_pc_update  = 1'b1;
                w_src_b      = 2'b10;
                w_result_src = 2'b10;
            end
            S_DECODE: begin
                w_src_a = 2'b01;
                w_src_b = 2'b01;
            end
            S_MEMADR: begin
                w_src_a = 2'b10;
                w_src_b = 2'b01;
            end
            S_MEMREAD:  w_adr_src = 1'b1;
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                w_src_a  = 2'b10;
                w_alu_op = 2'b10;
            end
            S_ALUWB:    w_reg_write = 1'b1;
            S_EXECI: begin
                w_src_a  = 2'b10;
                w_src_b  = 2'b01;
                w_alu_op = 2'b10;
            end
            S_JAL: begin
                w_src_a     = 2'b01;
                w_src_b     = 2'b10;
                w_pc_update = 1'b1;
            end
            S_BEQ: begin
                w_src_a  = 2'b10;
                w_alu_op = 2'b01;
                w_branch = 1'b1;
            end
            default: ;
        endcase
    end

    // Subtract only for R-type with funct7b5; addi ignores bit 30
    always_comb begin
        w_alu_ctrl = 3'b000;
        case (w_alu_op)
            2'b01: w_alu_ctrl = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  w_alu_ctrl = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  w_alu_ctrl = 3'b101;
                    3'b110:  w_alu_ctrl = 3'b011;
                    3'b111:  w_alu_ctrl = 3'b010;
                    default: w_alu_ctrl = 3'b000;
                endcase
            end
            default: w_alu_ctrl = 3'b000;
        endcase
    end

    always_comb begin
        unique case (bus.op)
            OP_SW:   w_imm_src = 2'b01;
            OP_BEQ:  w_imm_src = 2'b10;
            OP_JAL:  w_imm_src = 2'b11;
            default: w_imm_src = 2'b00;
        endcase
    end

    assign bus.PCWrite    = rst_n & (w_pc_update | (w_branch & bus.Zero));
    assign bus.IRWrite    = rst_n & w_ir_write;
    assign bus.MemWrite   = rst_n & w_mem_write;
    assign bus.RegWrite   = rst_n & w_reg_write;
    assign bus.AdrSrc     = w_adr_src;
    assign bus.ResultSrc  = w_result_src;
    assign bus.ALUSrcA    = w_src_a;
    assign bus.ALUSrcB    = w_src_b;
    assign bus.ALUControl = w_alu_ctrl;
    assign bus.ImmSrc     = w_imm_src;
    assign bus.illegal_op = (r_state == S_DECODE) & ~w_legal;
    assign bus.state      = r_state;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized check of the multicycle control unit against a per-instruction
// reference: expected state walk from the opcode, expected controls per step.
module tb_multicycle_control_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    multicycle_control_unit_if bus ();

    multicycle_control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BQ  = 7'b1100011;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        return op == LW || op == SW || op == RT ||
               op == IT || op == JL || op == BQ;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, ".state"},     bus.state,      0);
        check({tag, ".PCWrite"},   bus.PCWrite,    0);
        check({tag, ".IRWrite"},   bus.IRWrite,    0);
        check({tag, ".MemWrite"},  bus.MemWrite,   0);
        check({tag, ".RegWrite"},  bus.RegWrite,   0);
        check({tag, ".illegal"},   bus.illegal_op, 0);
        check({tag, ".ResultSrc"}, bus.ResultSrc,  2);
        check({tag, ".ALUSrcA"},   bus.ALUSrcA,    0);
        check({tag, ".ALUSrcB"},   bus.ALUSrcB,    2);
        check({tag, ".ALUCtl"},    bus.ALUControl, 0);
        check({tag, ".AdrSrc"},    bus.AdrSrc,     0);
    endtask

    // Called #1 after a rising edge with the DUT in FETCH; returns likewise.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input int zmode);
        int seq[$];
        int s;
        int e_pcw, e_irw, e_mw, e_rw, e_adr, e_res, e_a, e_b, e_alu, e_imm;
        bit upd, br;
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        case (op)
            LW:      seq = '{0, 1, 2, 3, 4};
            SW:      seq = '{0, 1, 2, 5};
            RT:      seq = '{0, 1, 6, 7};
            IT:      seq = '{0, 1, 8, 7};
            JL:      seq = '{0, 1, 9, 7};
            BQ:      seq = '{0, 1, 10};
            default: seq = '{0, 1};
        endcase
        e_imm = (op == SW) ? 1 : (op == BQ) ? 2 : (op == JL) ? 3 : 0;
        foreach (seq[k]) begin
            bus.Zero = (zmode < 0) ? 1'($urandom_range(1)) : 1'(zmode);
            s = seq[k];
            {e_irw, e_mw, e_rw, e_adr, e_res, e_a, e_b, e_alu} = '0;
            upd = 0;
            br  = 0;
            case (s)
                0:  begin e_irw = 1; upd = 1; e_b = 2; e_res = 2; end
                1:  begin e_a = 1; e_b = 1; end
                2:  begin e_a = 2; e_b = 1; end
                3:  e_adr = 1;
                4:  begin e_res = 1; e_rw = 1; end
                5:  begin e_adr = 1; e_mw = 1; end
                6, 8: begin
                    e_a = 2;
                    e_b = (s == 8) ? 1 : 0;
                    case (f3)
                        3'b000:  e_alu = (op == RT && f7) ? 1 : 0;
                        3'b010:  e_alu = 5;
                        3'b110:  e_alu = 3;
                        3'b111:  e_alu = 2;
                        default: e_alu = 0;
                    endcase
                end
                7:  e_rw = 1;
                9:  begin e_a = 1; e_b = 2; upd = 1; end
                10: begin e_a = 2; br = 1; e_alu = 1; end
                default: ;
            endcase
            e_pcw = (upd || (br && bus.Zero)) ? 1 : 0;
            @(negedge clk);
            check("state",     bus.state,      s);
            check("PCWrite",   bus.PCWrite,    e_pcw);
            check("IRWrite",   bus.IRWrite,    e_irw);
            check("MemWrite",  bus.MemWrite,   e_mw);
            check("RegWrite",  bus.RegWrite,   e_rw);
            check("AdrSrc",    bus.AdrSrc,     e_adr);
            check("ResultSrc", bus.ResultSrc,  e_res);
            check("ALUSrcA",   bus.ALUSrcA,    e_a);
            check("ALUSrcB",   bus.ALUSrcB,    e_b);
            check("ALUCtl",    bus.ALUControl, e_alu);
            check("ImmSrc",    bus.ImmSrc,     e_imm);
            check("illegal",   bus.illegal_op, (s == 1 && !is_legal(op)) ? 1 : 0);
            @(posedge clk);
            #1;
        end
    endtask

    logic [6:0] rop;
    int         pick;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.op = '0;
        bus.funct3 = '0;
        bus.funct7b5 = 1'b0;
        bus.Zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;

        run_instr(LW, 3'b010, 1'b0, -1);
        run_instr(RT, 3'b000, 1'b1, -1);
        run_instr(IT, 3'b010, 1'b0, -1);
        run_instr(IT, 3'b000, 1'b1, -1);
        run_instr(BQ, 3'b000, 1'b0, 1);
        run_instr(BQ, 3'b000, 1'b0, 0);
        run_instr(SW, 3'b010, 1'b0, -1);
        run_instr(JL, 3'b000, 1'b0, -1);
        run_instr(7'b1111111, 3'b000, 1'b0, -1);

        // Abandon an R-type while in EXECR
        bus.op = RT;
        bus.funct3 = 3'b000;
        bus.funct7b5 = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        check("pre_rst.state", bus.state, 6);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_mid_edge");
        rst_n = 1'b1;
        run_instr(RT, 3'b000, 1'b1, -1);

        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(6);
            case (pick)
                0: rop = LW;
                1: rop = SW;
                2: rop = RT;
                3: rop = IT;
                4: rop = JL;
                5: rop = BQ;
                default: begin
                    rop = 7'($urandom);
                    while (is_legal(rop)) rop = 7'($urandom);
                end
            endcase
            run_instr(rop, 3'($urandom), 1'($urandom), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle control unit for the RISC-V datapath: it decodes the latched instruction fields and drives the select and write-enable lines of the shared datapath, including the 3-bit `ALUControl` consumed by the 32-bit ALU. It uses the ALU `Zero` flag to resolve branches. The block is a Moore main FSM plus a combinational ALU decoder and an immediate-format decoder. It replaces the single-cycle decoder when the datapath uses one memory and one ALU over several cycles.

## Interface
- No parameters; all widths are fixed by the RV32I subset (lw, sw, R-type add/sub/and/or/slt, I-type addi/andi/ori/slti, beq, jal).
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 7: instruction bits [6:0] from the instruction register.
- `funct3` in 3: instruction bits [14:12].
- `funct7b5` in 1: instruction bit 30.
- `Zero` in 1: ALU zero flag.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select; 0 selects PC, 1 selects Result.
- `MemWrite` out 1: data memory write strobe.
- `IRWrite` out 1: instruction register and OldPC enable.
- `ResultSrc` out 2: Result select; 00 ALUOut, 01 Data, 10 ALUResult.
- `ALUSrcA` out 2: ALU A select; 00 PC, 01 OldPC, 10 rs1 register.
- `ALUSrcB` out 2: ALU B select; 00 rs2 register, 01 ImmExt, 10 constant 4.
- `ALUControl` out 3: ALU operation; 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `ImmSrc` out 2: immediate format; 00 I, 01 S, 10 B, 11 J.
- `RegWrite` out 1: register file write enable.
- `illegal_op` out 1: unsupported opcode was seen in Decode.
- `state` out 4: current FSM state, for debug.

## Operation
- **State encoding:** FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10. Codes 11–15 are unreachable; if entered, the next state is FETCH.
- **Transitions:**
  - FETCH→DECODE.
  - DECODE: 0000011 or 0100011→MEMADR; 0110011→EXECR; 0010011→EXECI; 1101111→JAL; 1100011→BEQ; any other opcode→FETCH.
  - MEMADR: lw→MEMREAD, sw→MEMWRITE.
  - MEMREAD→MEMWB.
  - EXECR, EXECI and JAL→ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ→FETCH.
- **Moore outputs per state.** Any signal not listed is 0, and ALUOp defaults to 00.
  - FETCH: IRWrite=1, PCUpdate=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=01, ALUSrcB=01 (computes the branch target).
  - MEMADR: ALUSrcA=10, ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - ALUWB: RegWrite=1.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, Branch=1.
- **PCWrite** = PCUpdate | (Branch & Zero).
- **ALU decoder** (combinational from ALUOp, funct3, op[5], funct7b5):
  - ALUOp 00 gives 000; ALUOp 01 gives 001.
  - ALUOp 10, funct3 000: if {op[5],funct7b5}=11, output 001; otherwise 000.
  - ALUOp 10, funct3 010 gives 101; 110 gives 011; 111 gives 010; any other funct3 gives 000.
- **ImmSrc** (combinational from op, independent of state): 0100011→01, 1100011→10, 1101111→11, otherwise 00.
- **illegal_op** = (state==DECODE) and op is not one of the six supported opcodes. It lasts exactly one cycle per offending instruction.

## Timing
- **Reset:** `rst_n`=0 forces state=FETCH immediately (asynchronous). While `rst_n`=0:
  - PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - illegal_op is 0.
  - ResultSrc=10, ALUSrcA=00, ALUSrcB=10, ALUControl=000, AdrSrc=0.
- **Release:** first FETCH cycle is the first rising edge after `rst_n` goes high.
- **Reset mid-instruction:** the instruction is abandoned, no further write enables are asserted, and execution restarts at FETCH.
- **Latency in cycles, FETCH through last state:** lw 5; sw 4; R-type 4; I-type 4; jal 4; beq 3; illegal opcode 2.
- **Output timing:** all outputs are combinational from state and the instruction fields, valid within the same cycle.
- **Branch resolution:** `Zero` is sampled only in BEQ; PCWrite follows `Zero` combinationally in that cycle.
- **No stalls:** the FSM advances every cycle, with no stall or handshake input; memory is single-cycle.

## Test plan
- **Reset behaviour:**
  - Stimulus: assert `rst_n`=0 asynchronously mid-cycle while in EXECR.
  - Response: state=0 at once; PCWrite, IRWrite, MemWrite and RegWrite all 0.
  - Stimulus: release `rst_n`.
  - Response: FETCH cycle with IRWrite=1, PCWrite=1, ALUSrcB=10, ALUControl=000.
- **lw (op=0000011, funct3=010):**
  - Response: state sequence 0,1,2,3,4,0.
  - MEMREAD has AdrSrc=1; MEMWB has ResultSrc=01 and RegWrite=1.
  - ImmSrc=00 throughout.
- **sub, then slti:**
  - sub (op=0110011, funct3=000, funct7b5=1): state sequence 0,1,6,7,0, with ALUControl=001 in EXECR.
  - slti (op=0010011, funct3=010): ALUControl=101 in EXECI.
  - addi with funct7b5=1 (op=0010011, funct3=000): ALUControl=000.
- **beq (op=1100011):**
  - Zero=1 in BEQ: PCWrite=1, ALUControl=001, ImmSrc=10.
  - Zero=0 in BEQ: PCWrite=0.
  - Both cases return to FETCH after 3 cycles.
- **sw and jal:**
  - sw (op=0100011): state sequence 0,1,2,5,0, MemWrite=1 only in state 5, ImmSrc=01.
  - jal (op=1101111): state sequence 0,1,9,7,0, PCWrite=1 in JAL, ImmSrc=11.
- **Illegal opcode (op=1111111):**
  - illegal_op=1 for one cycle in DECODE.
  - Next state is FETCH.
  - No RegWrite or MemWrite is asserted during the instruction.
